// File: rtl/resp_meter_if.sv
// resp_meter_if: sample-stream inputs and result handshake of the response meter.
// master = the side feeding samples and consuming results; slave = the meter.
interface resp_meter_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] i_data;
    logic                     i_valid;
    logic                     i_cfg_valid;
    logic        [DATA_W-2:0] o_peak;
    logic        [DATA_W-2:0] o_mean;
    logic                     o_valid;
    logic                     i_ready;
    logic        [15:0]       o_win_cnt;
    logic                     o_overrun;

    modport master (
        output i_data, i_valid, i_cfg_valid, i_ready,
        input  o_peak, o_mean, o_valid, o_win_cnt, o_overrun
    );

    modport slave (
        input  i_data, i_valid, i_cfg_valid, i_ready,
        output o_peak, o_mean, o_valid, o_win_cnt, o_overrun
    );
endinterface

// File: rtl/resp_meter.sv
// resp_meter: amplitude-response meter for a swept test signal.
// After each config strobe it discards SETTLE_LEN valid samples, then reports
// peak |x| and mean |x| for consecutive WIN_LEN-sample windows through a
// valid/ready handshake.
// Optional feature macro: RESP_METER_MEAN_EN builds the |x| accumulator and
// the mean output; without it o_mean is tied to zero.
module resp_meter #(
    parameter int DATA_W     = 16,
    parameter int WIN_LEN    = 1024,
    parameter int SETTLE_LEN = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    resp_meter_if.slave  bus
);
    localparam int LOG2_WIN = $clog2(WIN_LEN);
    localparam int SET_W    = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
    localparam logic [LOG2_WIN-1:0] WIN_LAST = LOG2_WIN'(WIN_LEN - 1);
    localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2
    } state_t;

    // With no settling interval a config strobe goes straight to measuring.
    localparam state_t START_ST = (SETTLE_LEN == 0) ? ST_ACCUM : ST_SETTLE;

    // Saturating magnitude: the most negative code maps to the largest positive one.
    function automatic logic [DATA_W-2:0] abs_sat(input logic [DATA_W-1:0] x);
        logic [DATA_W-2:0] neg;
        neg = (~x[DATA_W-2:0]) + {{(DATA_W-2){1'b0}}, 1'b1};
        if (!x[DATA_W-1]) begin
            abs_sat = x[DATA_W-2:0];
        end else if (x[DATA_W-2:0] == {(DATA_W-1){1'b0}}) begin
            abs_sat = {(DATA_W-1){1'b1}};
        end else begin
            abs_sat = neg;
        end
    endfunction

    state_t              state_r;
    logic [LOG2_WIN-1:0] win_cnt_r;
    logic [SET_W-1:0]    set_cnt_r;
    logic [DATA_W-2:0]   peak_r;

    logic [DATA_W-2:0]   abs_s;
    logic [DATA_W-2:0]   peak_next_s;
    logic [DATA_W-2:0]   mean_next_s;
    logic                take_s;
    logic                win_done_s;

    logic [DATA_W-2:0]   peak_out_r;
    logic [DATA_W-2:0]   mean_out_r;
    logic                valid_r;
    logic [15:0]         win_total_r;
    logic                overrun_r;

    // Sample magnitude, accept qualifier and window-complete detection.
    always_comb begin
        abs_s       = abs_sat(bus.i_data);
        take_s      = 1'b0;
        win_done_s  = 1'b0;
        if (!bus.i_cfg_valid && bus.i_valid && (state_r == ST_ACCUM)) begin
            take_s     = 1'b1;
            win_done_s = (win_cnt_r == WIN_LAST);
        end else begin
            take_s     = 1'b0;
            win_done_s = 1'b0;
        end
        if (abs_s > peak_r) begin
            peak_next_s = abs_s;
        end else begin
            peak_next_s = peak_r;
        end
    end

`ifdef RESP_METER_MEAN_EN
    localparam int ACC_W = DATA_W - 1 + LOG2_WIN;

    logic [ACC_W-1:0] sum_r;
    logic [ACC_W-1:0] sum_next_s;

    // Running |x| sum including the current sample; the mean is a plain shift.
    always_comb begin
        sum_next_s  = sum_r + ACC_W'(abs_s);
        mean_next_s = sum_next_s[ACC_W-1:LOG2_WIN];
    end

    // |x| accumulator: cleared by a strobe and at every window boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r <= {ACC_W{1'b0}};
        end else if (bus.i_cfg_valid) begin
            sum_r <= {ACC_W{1'b0}};
        end else if (take_s) begin
            sum_r <= win_done_s ? {ACC_W{1'b0}} : sum_next_s;
        end
    end
`else
    assign mean_next_s = {(DATA_W-1){1'b0}};
`endif

    // Measurement FSM with settle/window counters and running peak.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            win_cnt_r <= {LOG2_WIN{1'b0}};
            set_cnt_r <= {SET_W{1'b0}};
            peak_r    <= {(DATA_W-1){1'b0}};
        end else if (bus.i_cfg_valid) begin
            // Restart: the partial window and any same-cycle sample are dropped.
            state_r   <= START_ST;
            win_cnt_r <= {LOG2_WIN{1'b0}};
            set_cnt_r <= {SET_W{1'b0}};
            peak_r    <= {(DATA_W-1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_SETTLE: begin
                    if (bus.i_valid) begin
                        if (set_cnt_r == SET_LAST) begin
                            state_r   <= ST_ACCUM;
                            set_cnt_r <= {SET_W{1'b0}};
                        end else begin
                            set_cnt_r <= set_cnt_r + SET_W'(1);
                        end
                    end
                end
                ST_ACCUM: begin
                    if (take_s) begin
                        if (win_done_s) begin
                            win_cnt_r <= {LOG2_WIN{1'b0}};
                            peak_r    <= {(DATA_W-1){1'b0}};
                        end else begin
                            win_cnt_r <= win_cnt_r + LOG2_WIN'(1);
                            peak_r    <= peak_next_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Result handshake: publish, hold under backpressure, flag dropped windows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_out_r  <= {(DATA_W-1){1'b0}};
            mean_out_r  <= {(DATA_W-1){1'b0}};
            valid_r     <= 1'b0;
            win_total_r <= 16'd0;
            overrun_r   <= 1'b0;
        end else if (win_done_s) begin
            win_total_r <= win_total_r + 16'd1;
            if (!valid_r || bus.i_ready) begin
                peak_out_r <= peak_next_s;
                mean_out_r <= mean_next_s;
                valid_r    <= 1'b1;
            end else begin
                overrun_r  <= 1'b1;
            end
        end else if (valid_r && bus.i_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign bus.o_peak    = peak_out_r;
    assign bus.o_mean    = mean_out_r;
    assign bus.o_valid   = valid_r;
    assign bus.o_win_cnt = win_total_r;
    assign bus.o_overrun = overrun_r;
endmodule

// File: tb/tb_resp_meter.sv
// tb_resp_meter: directed stimulus with a result scoreboard for resp_meter
// (WIN_LEN=8, SETTLE_LEN=2). Expected mean follows RESP_METER_MEAN_EN.
module tb_resp_meter;
    localparam int DW = 16;
    localparam int WL = 8;
    localparam int SL = 2;

    typedef struct {
        logic [DW-2:0] peak;
        logic [DW-2:0] mean;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #10 clk = ~clk;

    resp_meter_if #(.DATA_W(DW)) bus();

    resp_meter #(.DATA_W(DW), .WIN_LEN(WL), .SETTLE_LEN(SL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic int em(input int m);
`ifdef RESP_METER_MEAN_EN
        return m;
`else
        return 0 * m;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_res(input int p, input int m);
        exp_t e;
        e.peak = 15'(p);
        e.mean = 15'(em(m));
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; inputs change 1 time unit after the active edge.
    task automatic drive(input logic v, input int d, input logic cfg);
        bus.i_valid     = v;
        bus.i_data      = 16'(d);
        bus.i_cfg_valid = cfg;
        @(posedge clk);
        #1;
        bus.i_valid     = 1'b0;
        bus.i_cfg_valid = 1'b0;
    endtask

    task automatic send(input int d);
        drive(1'b1, d, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    task automatic strobe();
        drive(1'b0, 0, 1'b1);
    endtask

    // Scoreboard monitor: every accepted result must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_peak", int'(bus.o_peak), int'(mon_e.peak));
                check("sb_mean", int'(bus.o_mean), int'(mon_e.mean));
            end
        end
    end

    int w1[8] = '{100, -200, 300, -400, 500, -600, 700, -32768};

    initial begin
        bus.i_data      = 16'sd0;
        bus.i_valid     = 1'b0;
        bus.i_cfg_valid = 1'b0;
        bus.i_ready     = 1'b1;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_peak", int'(bus.o_peak), 0);
        check("rst_mean", int'(bus.o_mean), 0);
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_win_cnt", int'(bus.o_win_cnt), 0);
        check("rst_overrun", int'(bus.o_overrun), 0);
        rst_n = 1'b1;

        // Idle: samples without a config strobe produce nothing.
        for (int i = 0; i < 20; i++) send(i * 1500 - 16000);
        check("idle_valid", int'(bus.o_valid), 0);
        check("idle_win_cnt", int'(bus.o_win_cnt), 0);
        check("idle_peak", int'(bus.o_peak), 0);

        // Basic window, held with i_ready low to inspect latency and stability.
        bus.i_ready = 1'b0;
        expect_res(32767, 4445);
        strobe();
        send(1000);
        send(-2000);
        gap(1);
        foreach (w1[i]) send(w1[i]);
        check("basic_valid", int'(bus.o_valid), 1);
        check("basic_peak", int'(bus.o_peak), 32767);
        check("basic_mean", int'(bus.o_mean), em(4445));
        check("basic_win_cnt", int'(bus.o_win_cnt), 1);
        gap(2);
        check("basic_hold_peak", int'(bus.o_peak), 32767);
        check("basic_hold_valid", int'(bus.o_valid), 1);
        bus.i_ready = 1'b1;
        gap(1);
        check("basic_accept_clear", int'(bus.o_valid), 0);

        // Gaps and restart: partial window discarded, sample on strobe cycle dropped.
        expect_res(80, 45);
        strobe();
        send(7000);
        send(-7000);
        send(5000); gap(2); send(-6000); gap(1); send(9000); send(4000); gap(3); send(8000);
        drive(1'b1, 30000, 1'b1);
        send(1); gap(1); send(2);
        send(10); send(-20); send(30); gap(1); send(-40); send(50); gap(2);
        send(-60); send(70); send(-80);
        check("restart_valid", int'(bus.o_valid), 1);
        check("restart_peak", int'(bus.o_peak), 80);
        check("restart_win_cnt", int'(bus.o_win_cnt), 2);
        gap(1);

        // Continuous stream with a consumer always ready: no overrun.
        strobe();
        send(3); send(-3);
        for (int k = 0; k < 3; k++) begin
            expect_res((k + 1) * 111, (k + 1) * 111);
            for (int i = 0; i < WL; i++) send(((i % 2) == 0) ? (k + 1) * 111 : -(k + 1) * 111);
        end
        check("cont_overrun", int'(bus.o_overrun), 0);
        check("cont_win_cnt", int'(bus.o_win_cnt), 5);
        gap(1);

        // Accept coincides with publish of the next window.
        bus.i_ready = 1'b0;
        expect_res(1000, 1000);
        expect_res(2500, 2062);
        strobe();
        send(9); send(9);
        for (int i = 0; i < WL; i++) send(((i % 2) == 0) ? 1000 : -1000);
        for (int i = 0; i < WL - 1; i++) send(2000);
        bus.i_ready = 1'b1;
        send(-2500);
        check("simul_valid", int'(bus.o_valid), 1);
        check("simul_peak", int'(bus.o_peak), 2500);
        check("simul_mean", int'(bus.o_mean), em(2062));
        check("simul_overrun", int'(bus.o_overrun), 0);
        check("simul_win_cnt", int'(bus.o_win_cnt), 7);
        gap(1);
        check("simul_clear", int'(bus.o_valid), 0);

        // Backpressure across two windows: first held, second dropped.
        bus.i_ready = 1'b0;
        expect_res(300, 300);
        strobe();
        send(4); send(4);
        for (int i = 0; i < WL; i++) send(300);
        for (int i = 0; i < WL; i++) send(-50);
        check("bp_valid", int'(bus.o_valid), 1);
        check("bp_peak", int'(bus.o_peak), 300);
        check("bp_mean", int'(bus.o_mean), em(300));
        check("bp_overrun", int'(bus.o_overrun), 1);
        check("bp_win_cnt", int'(bus.o_win_cnt), 9);
        bus.i_ready = 1'b1;
        gap(1);
        check("bp_clear", int'(bus.o_valid), 0);
        gap(2);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
